// File: rtl/ifetch_pkg.sv
// Shared pipeline definitions: widths, NOP encoding
// and the fetch-stage FSM state encodings.
package ifetch_pkg;

  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 4;
  localparam int REG_N    = 8;

  // Encoding decode treats as a no-op; also the
  // power-on contents of the instruction register.
  localparam logic [15:0] NOP_INST = 16'h0000;

  // Fetch FSM: one request phase, one issue phase.
  localparam logic IF_S_REQ   = 1'b0;
  localparam logic IF_S_ISSUE = 1'b1;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: holds the PC, fetches one
// instruction over imem req/ack, issues it to decode
// over valid/ready, loads the next PC from branch
// control on each accept, and squashes to NOP while
// nop_en is high.
// Ports: clk, reset (sync, active-high);
//   pc_bout, nop_en  <- branch control
//   pc_out           -> branch control pc_in
//   imem_req/addr/ack/rdata  instruction memory
//   inst_valid/ready/out     decode handshake
// Optional (IFETCH_PERF_CNT_EN): issue_cnt and
//   squash_cnt accept counters, wrapping at 16 bits.
module ifetch #(
  parameter int          DATA_W   = 16,
  parameter int          INST_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_bout,
  input  logic              nop_en,
  output logic [DATA_W-1:0] pc_out,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
`ifdef IFETCH_PERF_CNT_EN
  output logic [15:0]       issue_cnt,
  output logic [15:0]       squash_cnt,
`endif
  output logic [INST_W-1:0] inst_out
);

  import ifetch_pkg::*;

  localparam logic [INST_W-1:0] NOP_W =
    INST_W'(NOP_INST);
  localparam logic [DATA_W-1:0] RST_PC_W =
    DATA_W'(RESET_PC);

  logic              state_q;
  logic [DATA_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic              accept;

  assign accept = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IF_S_REQ;
      pc_q    <= RST_PC_W;
      inst_q  <= NOP_W;
    end else begin
      unique case (state_q)
        IF_S_REQ: begin
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            state_q <= IF_S_ISSUE;
          end
        end
        IF_S_ISSUE: begin
          // A squashed accept still takes the
          // redirect target from branch control.
          if (inst_ready) begin
            pc_q    <= pc_bout;
            state_q <= IF_S_REQ;
          end
        end
        default: state_q <= IF_S_REQ;
      endcase
    end
  end

  assign imem_req   = (state_q == IF_S_REQ);
  assign inst_valid = (state_q == IF_S_ISSUE);
  assign pc_out     = pc_q;
  assign imem_addr  = pc_q;

  // Same-cycle squash: nop_en gates the held word.
  assign inst_out = nop_en ? NOP_W : inst_q;

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt  <= 16'h0000;
      squash_cnt <= 16'h0000;
    end else if (accept) begin
      if (nop_en)
        squash_cnt <= squash_cnt + 16'h0001;
      else
        issue_cnt  <= issue_cnt + 16'h0001;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
